// File: rtl/fetch_stage.sv
// IF stage: owns the PC, reads combinational imem, and registers the word into IF/ID one edge later.
// Priority redirect > stall > normal; define FETCH_JAL_PREDICT_EN to steer fetch to JAL targets at predecode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instruction,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [31:0] id_instruction,
  output logic        id_valid,
  output logic        id_pred_taken,
  output logic        fetch_misaligned
);

  logic [31:0] pc_q;
  logic [31:0] next_pc;

  assign imem_pc = pc_q;

`ifdef FETCH_JAL_PREDICT_EN
  logic        is_jal;
  logic [31:0] jal_imm;
  logic        pred_q;

  assign is_jal  = (imem_instruction[6:0] == 7'b1101111);
  // J-type immediate: imm[20|10:1|11|19:12] scattered across the word, bit 0 implied zero.
  assign jal_imm = {{11{imem_instruction[31]}}, imem_instruction[31], imem_instruction[19:12],
                    imem_instruction[20], imem_instruction[30:21], 1'b0};
  assign next_pc = is_jal ? (pc_q + jal_imm) : (pc_q + 32'd4);

  // Any kill (reset, redirect, flush) clears the flag; a stall without flush holds it.
  always_ff @(posedge clk) begin
    if (!rst_n || redirect_valid || flush) begin
      pred_q <= 1'b0;
    end else if (!stall) begin
      pred_q <= is_jal;
    end
  end

  assign id_pred_taken = pred_q;
`else
  assign next_pc       = pc_q + 32'd4;
  assign id_pred_taken = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q             <= RESET_PC;
      id_pc            <= 32'h0000_0000;
      id_pc_plus4      <= 32'h0000_0004;
      id_instruction   <= NOP_INSTR;
      id_valid         <= 1'b0;
      fetch_misaligned <= 1'b0;
    end else begin
      fetch_misaligned <= redirect_valid & (|redirect_pc[1:0]);
      if (redirect_valid) begin
        // Target is force-aligned; the misaligned pulse reports the dropped bits.
        pc_q           <= {redirect_pc[31:2], 2'b00};
        id_instruction <= NOP_INSTR;
        id_valid       <= 1'b0;
      end else if (stall) begin
        if (flush) begin
          id_instruction <= NOP_INSTR;
          id_valid       <= 1'b0;
        end
      end else begin
        pc_q <= next_pc;
        if (flush) begin
          id_instruction <= NOP_INSTR;
          id_valid       <= 1'b0;
        end else begin
          id_pc          <= pc_q;
          id_pc_plus4    <= pc_q + 32'd4;
          id_instruction <= imem_instruction;
          id_valid       <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: per-cycle comparison against a spec-level model plus directed literal checks.
module tb_fetch_stage;

`ifdef FETCH_JAL_PREDICT_EN
  localparam bit PREDICT = 1'b1;
`else
  localparam bit PREDICT = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_pc, imem_instruction;
  logic [31:0] id_pc, id_pc_plus4, id_instruction;
  logic        id_valid, id_pred_taken, fetch_misaligned;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_pc(imem_pc), .imem_instruction(imem_instruction),
    .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .id_instruction(id_instruction),
    .id_valid(id_valid), .id_pred_taken(id_pred_taken), .fetch_misaligned(fetch_misaligned)
  );

  always #5 clk = ~clk;

  // 256-byte instruction memory; anything above reads as a NOP.
  logic [31:0] mem [0:63];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'd256) return mem[a[7:2]];
    return NOP;
  endfunction

  assign imem_instruction = mem_word(imem_pc);

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic is_jal(input logic [31:0] w);
    return w[6:0] == 7'b1101111;
  endfunction

  function automatic logic [31:0] jal_target(input logic [31:0] pc, input logic [31:0] w);
    logic signed [20:0] off;
    off = {w[31], w[19:12], w[20], w[30:21], 1'b0};
    return pc + 32'(off);
  endfunction

  // Model state: what the spec says PC and IF/ID must hold after each edge.
  logic        m_known = 1'b0;
  logic [31:0] m_pc, m_id_pc, m_id_p4, m_instr, m_w;
  logic        m_vld, m_pred, m_mis;

  always @(posedge clk) begin
    m_w = mem_word(m_pc);
    if (!rst_n) begin
      m_known = 1'b1;
      m_pc = 32'h0; m_id_pc = 32'h0; m_id_p4 = 32'h4; m_instr = NOP;
      m_vld = 1'b0; m_pred = 1'b0; m_mis = 1'b0;
    end else if (m_known) begin
      m_mis = redirect_valid && (redirect_pc[1:0] != 2'b00);
      if (redirect_valid) begin
        m_pc = redirect_pc & ~32'h3;
        m_instr = NOP; m_vld = 1'b0; m_pred = 1'b0;
      end else if (stall) begin
        if (flush) begin m_instr = NOP; m_vld = 1'b0; m_pred = 1'b0; end
      end else begin
        if (flush) begin
          m_instr = NOP; m_vld = 1'b0; m_pred = 1'b0;
        end else begin
          m_id_pc = m_pc; m_id_p4 = m_pc + 32'd4; m_instr = m_w; m_vld = 1'b1;
          m_pred = PREDICT && is_jal(m_w);
        end
        m_pc = (PREDICT && is_jal(m_w)) ? jal_target(m_pc, m_w) : m_pc + 32'd4;
      end
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      chk("m_imem_pc", imem_pc, m_pc);
      chk("m_id_pc", id_pc, m_id_pc);
      chk("m_id_pc_plus4", id_pc_plus4, m_id_p4);
      chk("m_id_instruction", id_instruction, m_instr);
      chk("m_id_valid", 32'(id_valid), 32'(m_vld));
      chk("m_id_pred_taken", 32'(id_pred_taken), 32'(m_pred));
      chk("m_fetch_misaligned", 32'(fetch_misaligned), 32'(m_mis));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = {12'(i), 5'd0, 3'b000, 5'd1, 7'h13};
    mem[0]  = 32'hfe010113;
    mem[1]  = 32'h00812e23;
    mem[21] = 32'hfadff0ef;

    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    step(); step();
    chk("rst_imem_pc", imem_pc, 32'h0);
    chk("rst_id_instruction", id_instruction, 32'h13);
    chk("rst_id_valid", 32'(id_valid), 32'h0);
    chk("rst_id_pc_plus4", id_pc_plus4, 32'h4);

    rst_n = 1'b1;
    step();
    chk("seq1_id_pc", id_pc, 32'h0);
    chk("seq1_id_instruction", id_instruction, 32'hfe010113);
    chk("seq1_id_valid", 32'(id_valid), 32'h1);
    step();
    chk("seq2_id_pc", id_pc, 32'h4);
    chk("seq2_id_instruction", id_instruction, 32'h00812e23);
    chk("seq2_imem_pc", imem_pc, 32'h8);

    stall = 1'b1;
    step();
    chk("stall_imem_pc", imem_pc, 32'h8);
    chk("stall_id_pc", id_pc, 32'h4);
    chk("stall_id_instruction", id_instruction, 32'h00812e23);
    flush = 1'b1;
    step();
    chk("stflush_imem_pc", imem_pc, 32'h8);
    chk("stflush_id_valid", 32'(id_valid), 32'h0);
    chk("stflush_id_instruction", id_instruction, 32'h13);

    flush = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h34;
    step();
    chk("redir_imem_pc", imem_pc, 32'h34);
    chk("redir_id_valid", 32'(id_valid), 32'h0);
    chk("redir_id_instruction", id_instruction, 32'h13);
    chk("redir_misaligned", 32'(fetch_misaligned), 32'h0);

    stall = 1'b0; redirect_pc = 32'h36;
    step();
    chk("mis_imem_pc", imem_pc, 32'h34);
    chk("mis_pulse", 32'(fetch_misaligned), 32'h1);
    redirect_valid = 1'b0;
    step();
    chk("mis_cleared", 32'(fetch_misaligned), 32'h0);
    chk("mis_after_id_pc", id_pc, 32'h34);

    redirect_valid = 1'b1; redirect_pc = 32'h54;
    step();
    redirect_valid = 1'b0;
    step();
    chk("jal_id_pc", id_pc, 32'h54);
    chk("jal_id_instruction", id_instruction, 32'hfadff0ef);
    chk("jal_imem_pc", imem_pc, PREDICT ? 32'h0 : 32'h58);
    chk("jal_pred_taken", 32'(id_pred_taken), PREDICT ? 32'h1 : 32'h0);

    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_id_valid", 32'(id_valid), 32'h0);

    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    step();
    chk("wrap_imem_pc", imem_pc, 32'h0);
    chk("wrap_id_pc_plus4", id_pc_plus4, 32'h0);

    rst_n = 1'b0; stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
    step();
    chk("rstwin_imem_pc", imem_pc, 32'h0);
    chk("rstwin_id_valid", 32'(id_valid), 32'h0);
    rst_n = 1'b1; stall = 1'b0; redirect_valid = 1'b0;

    for (int i = 0; i < 12; i++) begin
      stall = (i % 3 == 1);
      flush = (i % 5 == 2);
      step();
    end
    stall = 1'b0; flush = 1'b0;
    step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
